// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- program-counter unit at the head of the datapath.
//
// Holds the fetch address, steps it by STEP on every accepted fetch, and
// honours stall and redirect (branch/jump) requests. The address is offered to
// instruction memory through a valid/ready handshake (pc_valid/fetch_ready).
//
// Optional feature macro: PC_RAS_EN
//   defined   : a circular return-address stack (RAS) is built; call/ret are
//               live and ras_empty/ras_full/ras_err report its state.
//   undefined : no RAS storage; call/ret are ignored; ras_empty=1,
//               ras_full=0, ras_err=0.
//
// All registers update on the falling edge of clk so the unit lines up with
// the rest of the datapath; rst_n is a synchronous active-low reset sampled on
// that same edge.
//
// Ports
//   clk             in   clock (state changes on negedge)
//   rst_n           in   synchronous reset, active-low
//   stall           in   hold pc_out this cycle
//   redirect_valid  in   load redirect_target (aligned to STEP)
//   redirect_target in   [WIDTH] branch/jump/call destination
//   call            in   push return address (together with redirect_valid)
//   ret             in   pop RAS top into pc_out
//   fetch_ready     in   instruction memory accepts pc_out
//   pc_out          out  [WIDTH] current fetch address (registered)
//   pc_valid        out  pc_out is a valid fetch request
//   ras_empty       out  RAS holds no entries
//   ras_full        out  RAS holds RAS_DEPTH entries
//   ras_err         out  sticky: ret issued while RAS empty
// -----------------------------------------------------------------------------
module pc_unit #(
   parameter int               WIDTH     = 32,
   parameter int               STEP      = 4,
   parameter logic [WIDTH-1:0] RESET_VEC = '0,
   parameter int               RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_target,
   input  logic             call,
   input  logic             ret,
   input  logic             fetch_ready,
   output logic [WIDTH-1:0] pc_out,
   output logic             pc_valid,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_err
);

   localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
   // STEP is a power of two, so clearing the bits below it aligns a target.
   localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP_W - WIDTH'(1));

   logic [WIDTH-1:0] pc_reg;
   logic [WIDTH-1:0] pc_next;
   logic             valid_reg;
   logic             adv;
   logic [WIDTH-1:0] seq_pc;
   logic [WIDTH-1:0] redirect_pc;

   assign adv         = valid_reg & fetch_ready & ~stall;
   // Natural wrap modulo 2^WIDTH is intended; no overflow flag exists.
   assign seq_pc      = adv ? (pc_reg + STEP_W) : pc_reg;
   assign redirect_pc = redirect_target & ALIGN_MASK;

`ifdef PC_RAS_EN
   localparam int             PW       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int             CW       = $clog2(RAS_DEPTH + 1);
   localparam logic [PW-1:0]  LAST_IDX = PW'(RAS_DEPTH - 1);
   localparam logic [CW-1:0]  DEPTH_C  = CW'(RAS_DEPTH);

   // Small register file rather than block RAM: a pop must return the top
   // entry in the same cycle it is requested, so the read is combinational.
   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]    top_reg, top_next, wr_idx;
   logic [CW-1:0]    count_reg, count_next;
   logic             empty_reg, full_reg, err_reg;
   logic             push, pop, underflow;
   logic [WIDTH-1:0] ret_addr;

   assign push      = call & redirect_valid;
   assign pop       = ret & (count_reg != '0);
   assign underflow = ret & (count_reg == '0);
   assign ret_addr  = pc_reg + STEP_W;

   // Pointer helpers handle non-power-of-two depths.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_IDX) ? '0 : p + PW'(1);
   endfunction

   function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
      return (p == '0) ? LAST_IDX : p - PW'(1);
   endfunction

   always_comb begin
      top_next   = top_reg;
      count_next = count_reg;
      wr_idx     = top_reg;
      if (push && pop) begin
         // Pop then push: the new return address replaces the old top.
         wr_idx = top_reg;
      end else if (push) begin
         // When full, the pointer lands on the oldest entry and overwrites it.
         top_next = ptr_inc(top_reg);
         wr_idx   = ptr_inc(top_reg);
         if (count_reg != DEPTH_C) begin
            count_next = count_reg + CW'(1);
         end
      end else if (pop) begin
         top_next   = ptr_dec(top_reg);
         count_next = count_reg - CW'(1);
      end
   end

   always_comb begin
      pc_next = seq_pc;
      if (redirect_valid) begin
         pc_next = redirect_pc;
      end else if (pop) begin
         pc_next = ras_mem[top_reg];
      end
   end

   always_ff @(negedge clk) begin
      if (!rst_n) begin
         top_reg   <= '0;
         count_reg <= '0;
         empty_reg <= 1'b1;
         full_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         top_reg   <= top_next;
         count_reg <= count_next;
         empty_reg <= (count_next == '0);
         full_reg  <= (count_next == DEPTH_C);
         if (underflow) begin
            err_reg <= 1'b1;
         end
      end
   end

   // Entries need no reset: count_reg alone decides what is valid.
   always_ff @(negedge clk) begin
      if (rst_n && push) begin
         ras_mem[wr_idx] <= ret_addr;
      end
   end

   assign ras_empty = empty_reg;
   assign ras_full  = full_reg;
   assign ras_err   = err_reg;
`else
   logic unused_ras;
   logic [31:0] unused_depth;

   assign unused_depth = RAS_DEPTH;
   assign unused_ras   = ^{call, ret, unused_depth};

   always_comb begin
      pc_next = seq_pc;
      if (redirect_valid) begin
         pc_next = redirect_pc;
      end
   end

   assign ras_empty = 1'b1;
   assign ras_full  = 1'b0;
   assign ras_err   = 1'b0;
`endif

   always_ff @(negedge clk) begin
      if (!rst_n) begin
         pc_reg    <= RESET_VEC;
         valid_reg <= 1'b0;
      end else begin
         pc_reg    <= pc_next;
         valid_reg <= 1'b1;
      end
   end

   assign pc_out   = pc_reg;
   assign pc_valid = valid_reg;

endmodule
